// File: rtl/sccb_target_regs.sv
// SCCB/I2C target with an 8-bit register file, oversampled on clk.
// sda is driven only after a detected scl fall, so it is stable while scl is high.
module sccb_target_regs #(
  parameter logic [7:0] DEVICE_ID   = 8'h42,
  parameter int         REG_DEPTH   = 64,
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] local_addr,
  output logic [7:0] local_data,
  output logic       wr_strobe,
  output logic [7:0] wr_reg,
  output logic [7:0] wr_value,
  output logic       busy
);
  localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, ACK_DEV, REG_ADDR, ACK_REG, WR_DATA, ACK_WR, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] sclSync_q, sdaSync_q;
  logic [3:0] bitCnt_q, bitCnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] tx_q, tx_d;
  logic       sdaLow_q, sdaLow_d;
  logic       phase_q, phase_d;
  logic       rdMode_q, rdMode_d;
  logic       busy_q, busy_d;
  logic       wrEn;
  logic       wrStrobe_q;
  logic [7:0] wrReg_q, wrValue_q, localData_q;
  logic [7:0] regs_q [REG_DEPTH];

  logic       sclS, sclPrev, sdaS, sdaPrev;
  logic       sclRise, sclFall, startDet, stopDet, ptrInRange;
  logic [7:0] rxByte, rdByte;

  // Index 1 is the synchronised level, index 2 the previous sample.
  assign sclS       = sclSync_q[1];
  assign sclPrev    = sclSync_q[2];
  assign sdaS       = sdaSync_q[1];
  assign sdaPrev    = sdaSync_q[2];
  assign sclRise    = sclS && !sclPrev;
  assign sclFall    = !sclS && sclPrev;
  assign startDet   = sclS && sdaPrev && !sdaS;
  assign stopDet    = sclS && !sdaPrev && sdaS;
  assign rxByte     = {shift_q[6:0], sdaS};
  assign ptrInRange = int'(ptr_q) < REG_DEPTH;
  assign rdByte     = ptrInRange ? regs_q[ptr_q[AW-1:0]] : 8'h00;

  assign sda        = sdaLow_q ? 1'b0 : 1'bz;
  assign local_data = localData_q;
  assign wr_strobe  = wrStrobe_q;
  assign wr_reg     = wrReg_q;
  assign wr_value   = wrValue_q;
  assign busy       = busy_q;

  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    tx_d     = tx_q;
    sdaLow_d = sdaLow_q;
    phase_d  = phase_q;
    rdMode_d = rdMode_q;
    busy_d   = busy_q;
    wrEn     = 1'b0;
    if (stopDet) begin
      state_d  = IDLE;
      sdaLow_d = 1'b0;
      phase_d  = 1'b0;
      busy_d   = 1'b0;
    end else if (startDet) begin
      state_d  = DEV_ADDR;
      bitCnt_d = '0;
      sdaLow_d = 1'b0;
      phase_d  = 1'b0;
    end else begin
      unique case (state_q)
        DEV_ADDR, REG_ADDR, WR_DATA: begin
          if (sclRise) begin
            shift_d  = rxByte;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd7) begin
              bitCnt_d = '0;
              if (state_q == DEV_ADDR) begin
                if (rxByte[7:1] == DEVICE_ID[7:1]) begin
                  state_d  = ACK_DEV;
                  rdMode_d = rxByte[0];
                  busy_d   = 1'b1;
                end else begin
                  state_d = IGNORE;
                end
              end else if (state_q == REG_ADDR) begin
                ptr_d   = rxByte;
                state_d = ACK_REG;
              end else begin
                state_d = ACK_WR;
              end
            end
          end
        end
        // phase_q marks that the ACK is being driven; the second fall ends it.
        ACK_DEV, ACK_REG, ACK_WR: begin
          if (sclFall) begin
            if (!phase_q) begin
              phase_d  = 1'b1;
              sdaLow_d = 1'b1;
              if (state_q == ACK_WR) begin
                wrEn  = ptrInRange;
                ptr_d = ptr_q + 8'd1;
              end
            end else begin
              phase_d  = 1'b0;
              sdaLow_d = 1'b0;
              if (state_q == ACK_DEV && rdMode_q) begin
                tx_d     = rdByte;
                sdaLow_d = ~rdByte[7];
                state_d  = RD_DATA;
              end else if (state_q == ACK_DEV) begin
                state_d = REG_ADDR;
              end else begin
                state_d = WR_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          if (sclRise) begin
            bitCnt_d = bitCnt_q + 4'd1;
          end else if (sclFall) begin
            if (bitCnt_q == 4'd8) begin
              bitCnt_d = '0;
              sdaLow_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = RD_ACK;
            end else begin
              sdaLow_d = ~tx_q[3'd7 - bitCnt_q[2:0]];
            end
          end
        end
        RD_ACK: begin
          if (sclRise && !phase_q) begin
            if (sdaS) begin
              state_d = IGNORE;
            end else begin
              ptr_d   = ptr_q + 8'd1;
              phase_d = 1'b1;
            end
          end else if (sclFall && phase_q) begin
            phase_d  = 1'b0;
            tx_d     = rdByte;
            sdaLow_d = ~rdByte[7];
            bitCnt_d = '0;
            state_d  = RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sclSync_q  <= '1;
      sdaSync_q  <= '1;
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      tx_q       <= '0;
      sdaLow_q   <= 1'b0;
      phase_q    <= 1'b0;
      rdMode_q   <= 1'b0;
      busy_q     <= 1'b0;
      wrStrobe_q <= 1'b0;
      wrReg_q    <= '0;
      wrValue_q  <= '0;
    end else begin
      sclSync_q  <= {sclSync_q[1:0], scl};
      sdaSync_q  <= {sdaSync_q[1:0], sda};
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      tx_q       <= tx_d;
      sdaLow_q   <= sdaLow_d;
      phase_q    <= phase_d;
      rdMode_q   <= rdMode_d;
      busy_q     <= busy_d;
      wrStrobe_q <= wrEn;
      if (wrEn) begin
        wrReg_q   <= ptr_q;
        wrValue_q <= shift_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= RESET_VALUE;
      localData_q <= '0;
    end else begin
      if (wrEn) regs_q[ptr_q[AW-1:0]] <= shift_q;
      localData_q <= (int'(local_addr) < REG_DEPTH) ? regs_q[local_addr[AW-1:0]] : 8'h00;
    end
  end
endmodule

// File: doc/sccb_target_regs.md
Name: sccb_target_regs

Overview:
- SCCB/I2C responder (target) and register bank; the far end of the camera configuration write path.
- Decodes START/STOP, matches the device address, ACKs, and writes register/data pairs into an internal register file.
- Serves reads: the pointer is set by a write phase, then bytes are read back using a repeated or new START.
- Used as a camera stand-in for bench/loopback checks of the configuration sequence, and for exposing written settings to local logic.

Parameters:
- DEVICE_ID, 8'h42, 8-bit write address. Read address is DEVICE_ID|1. Bit 0 of the parameter is ignored.
- REG_DEPTH, 64, number of implemented 8-bit registers at addresses 0..REG_DEPTH-1. Must be ≤256.
- RESET_VALUE, 8'h00, reset contents of every register.

Ports:
- clk  input  1  system clock. Must be ≥16× the SCL frequency.
- reset  input  1  synchronous, active-low reset.
- scl  input  1  bus clock. The target never stretches the clock.
- sda  inout  1  bus data, open-drain: driven 0 when pulling low, else 'bz.
- local_addr  input  8  local read address.
- local_data  output  8  register[local_addr], registered, 1-cycle latency. Returns 0 when local_addr ≥ REG_DEPTH.
- wr_strobe  output  1  one-cycle pulse per accepted data byte.
- wr_reg  output  8  register address of the last accepted write.
- wr_value  output  8  data of the last accepted write.
- busy  output  1  high from an address-matched START until STOP.

Behaviour:
- Input conditioning: scl and sda each pass through 2-flop synchronisers plus 1 history flop. Rising/falling edges come from the history. Bus events therefore act 3 clk after the pin changes.
- START: sda falls while scl is high → DEV_ADDR, bit counter cleared. Valid from any state, including mid-byte (repeated START).
- STOP: sda rises while scl is high → IDLE, sda released, busy=0. Valid from any state.
- Data bits are sampled on the scl rising edge, MSB first. Bit counter is 0..7.
- ACK/data timing: the target changes sda only on scl falling edges.
  - ACK: pull low on the falling edge after bit 8; release on the next falling edge.
- States and transitions:
  - IDLE: wait for START.
  - DEV_ADDR: shift 8 bits. Upper 7 bits ≠ DEVICE_ID[7:1] → IGNORE (no ACK). Match with R/W=0 → ACK_DEV→REG_ADDR. Match with R/W=1 → ACK_DEV→RD_DATA.
  - REG_ADDR: shift 8 bits → pointer, ACK → WR_DATA.
  - WR_DATA: shift 8 bits, ACK.
    - On the ACK falling edge: if pointer < REG_DEPTH, write the register and pulse wr_strobe with wr_reg=pointer, wr_value=byte.
    - Out-of-range bytes are still ACKed but not stored, and wr_strobe stays 0.
    - Pointer += 1, modulo 256. Stay in WR_DATA.
  - RD_DATA: load register[pointer] (0x00 if out of range) and drive bits MSB first, each changing on an scl falling edge. Bit 7 is presented on the falling edge that ends the ACK. A 1 bit means sda is released.
  - RD_ACK: release sda and sample the master's bit on scl rising. 0 (ACK) → pointer += 1, RD_DATA. 1 (NACK) → IGNORE.
  - IGNORE: sda released; wait for START/STOP.
- Write→read sequence: a write phase with only a register byte, then repeated START plus read address, reads from that pointer.
- The pointer persists across transactions until overwritten or reset.
- Simultaneous events: if START/STOP and an scl edge are detected in the same cycle, START/STOP wins.
- Reset (reset=0 at a clk edge): state=IDLE, sda released, pointer=0, all registers=RESET_VALUE, wr_strobe=0, wr_reg=0, wr_value=0, busy=0, local_data=0.
  - Applies mid-transaction; the target does not ACK again until a fresh START.

Test Plan:
- Write 0x42, reg 0x12, data 0x04, STOP → three ACKs; one wr_strobe with wr_reg=0x12, wr_value=0x04; local_addr=0x12 gives local_data=0x04 one cycle later.
- Address 0x44 followed by two bytes → sda never pulled low (NACK); no wr_strobe; busy stays 0; registers unchanged.
- Burst: 0x42, reg 0x3E, data 0xA1,0xB2,0xC3 → registers 0x3E,0x3F=0xA1,0xB2; 0x40 ≥ REG_DEPTH, so it is ACKed with no strobe and stays 0; exactly 2 strobes.
- Write 0x42, reg 0x3E; repeated START; 0x43; read two bytes with master ACK then NACK → 0xA1 then 0xB2; sda released after the NACK; pointer ends at 0x3F.
- reset=0 asserted while the target is driving the ACK → sda released next cycle; all registers read 0x00; the following valid transaction is ACKed normally.
- STOP injected after bit 4 of a data byte → no write, state IDLE; a new START is accepted immediately.
